// File: rtl/datapath_pkg.sv
// Shared widths and bus-source encoder codes for the bus-based CPU datapath.
package datapath_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ENC_W         = 5;
    localparam int unsigned NUM_GPR       = 16;
    localparam int unsigned NUM_SRC       = 24;
    localparam int unsigned NUM_CODES     = 32;

    localparam logic [ENC_W-1:0] SRC_R0     = 5'd0;
    localparam logic [ENC_W-1:0] SRC_HI     = 5'd16;
    localparam logic [ENC_W-1:0] SRC_LO     = 5'd17;
    localparam logic [ENC_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [ENC_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [ENC_W-1:0] SRC_PC     = 5'd20;
    localparam logic [ENC_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [ENC_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [ENC_W-1:0] SRC_Y      = 5'd23;
    localparam logic [ENC_W-1:0] SRC_NONE   = 5'd31;

endpackage

// File: rtl/datapath_reg32.sv
// Async-clear, enable-load register used for every datapath register.
module reg32 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// Bus-based CPU datapath: register file, source encoder, bus mux and small ALU.
// Optional signed multiply in the ALU when DATAPATH_MUL_EN is defined.
module datapath
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             R0in,  input logic R1in,  input logic R2in,  input logic R3in,
    input  logic             R4in,  input logic R5in,  input logic R6in,  input logic R7in,
    input  logic             R8in,  input logic R9in,  input logic R10in, input logic R11in,
    input  logic             R12in, input logic R13in, input logic R14in, input logic R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             INPORTin,
    input  logic             Zin,
    input  logic             Yin,
    input  logic             MARin,
    input  logic             IRin,
    input  logic             AND,
    input  logic             R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic             R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic             R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic             R12out, input logic R13out, input logic R14out, input logic R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHIout,
    input  logic             ZLOout,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             INPORTout,
    input  logic             Zout,
    input  logic             Yout,
    input  logic             Read,
    input  logic             IncPC,
`ifdef DATAPATH_MUL_EN
    input  logic             MUL,
`endif
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] busMuxOut,
    output logic [ENC_W-1:0] encoderOut,
    output logic [WIDTH-1:0] BusMuxInR0,  output logic [WIDTH-1:0] BusMuxInR1,
    output logic [WIDTH-1:0] BusMuxInR2,  output logic [WIDTH-1:0] BusMuxInR3,
    output logic [WIDTH-1:0] BusMuxInR4,  output logic [WIDTH-1:0] BusMuxInR5,
    output logic [WIDTH-1:0] BusMuxInR6,  output logic [WIDTH-1:0] BusMuxInR7,
    output logic [WIDTH-1:0] BusMuxInR8,  output logic [WIDTH-1:0] BusMuxInR9,
    output logic [WIDTH-1:0] BusMuxInR10, output logic [WIDTH-1:0] BusMuxInR11,
    output logic [WIDTH-1:0] BusMuxInR12, output logic [WIDTH-1:0] BusMuxInR13,
    output logic [WIDTH-1:0] BusMuxInR14, output logic [WIDTH-1:0] BusMuxInR15,
    output logic [WIDTH-1:0] BusMuxInHI,
    output logic [WIDTH-1:0] BusMuxInLO,
    output logic [WIDTH-1:0] BusMuxInZhi,
    output logic [WIDTH-1:0] BusMuxInZlo,
    output logic [WIDTH-1:0] BusMuxInPC,
    output logic [WIDTH-1:0] BusMuxInMDR,
    output logic [WIDTH-1:0] BusMuxInInport,
    output logic [WIDTH-1:0] BusMuxInY,
    input  logic             Resetn
);

    logic [NUM_GPR-1:0]   r_in;
    logic [NUM_GPR-1:0]   r_out;
    logic [NUM_SRC-1:0]   src_sel;
    logic [WIDTH-1:0]     r_q [NUM_GPR];
    logic [WIDTH-1:0]     src [NUM_CODES];
    logic [WIDTH-1:0]     hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, inport_q, y_q, zhi_q, zlo_q;
    logic [WIDTH-1:0]     mdr_d;
    logic [2*WIDTH-1:0]   alu_z;
    logic                 unused_regs;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Bit position equals encoder code; Zout is an alias for the Z low half.
    assign src_sel = {Yout, INPORTout, MDRout, PCout, ZLOout | Zout, ZHIout, LOout, HIout, r_out};

    for (genvar g = 0; g < int'(NUM_GPR); g++) begin : g_gpr
        reg32 #(.W(WIDTH)) u_r (.clk(Clock), .rst_n(Resetn), .en(r_in[g]), .d(busMuxOut), .q(r_q[g]));
    end

    assign mdr_d = Read ? Mdatain : busMuxOut;

    reg32 #(.W(WIDTH)) u_hi     (.clk(Clock), .rst_n(Resetn), .en(HIin),     .d(busMuxOut),            .q(hi_q));
    reg32 #(.W(WIDTH)) u_lo     (.clk(Clock), .rst_n(Resetn), .en(LOin),     .d(busMuxOut),            .q(lo_q));
    reg32 #(.W(WIDTH)) u_pc     (.clk(Clock), .rst_n(Resetn), .en(PCin),     .d(busMuxOut),            .q(pc_q));
    reg32 #(.W(WIDTH)) u_ir     (.clk(Clock), .rst_n(Resetn), .en(IRin),     .d(busMuxOut),            .q(ir_q));
    reg32 #(.W(WIDTH)) u_mar    (.clk(Clock), .rst_n(Resetn), .en(MARin),    .d(busMuxOut),            .q(mar_q));
    reg32 #(.W(WIDTH)) u_mdr    (.clk(Clock), .rst_n(Resetn), .en(MDRin),    .d(mdr_d),                .q(mdr_q));
    reg32 #(.W(WIDTH)) u_inport (.clk(Clock), .rst_n(Resetn), .en(INPORTin), .d(busMuxOut),            .q(inport_q));
    reg32 #(.W(WIDTH)) u_y      (.clk(Clock), .rst_n(Resetn), .en(Yin),      .d(busMuxOut),            .q(y_q));
    reg32 #(.W(WIDTH)) u_zhi    (.clk(Clock), .rst_n(Resetn), .en(Zin),      .d(alu_z[2*WIDTH-1:WIDTH]), .q(zhi_q));
    reg32 #(.W(WIDTH)) u_zlo    (.clk(Clock), .rst_n(Resetn), .en(Zin),      .d(alu_z[WIDTH-1:0]),     .q(zlo_q));

    // IR and MAR feed the control unit / memory, which sit outside this slice.
    assign unused_regs = ^{ir_q, mar_q};

    // Priority encoder: scanning downward leaves the lowest active code.
    always_comb begin
        encoderOut = SRC_NONE;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                encoderOut = ENC_W'(i);
            end
        end
    end

    // Unused codes (including SRC_NONE) read as zero, so an idle bus is 0.
    always_comb begin
        for (int i = 0; i < int'(NUM_CODES); i++) begin
            src[i] = '0;
        end
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            src[int'(SRC_R0) + i] = r_q[i];
        end
        src[SRC_HI]     = hi_q;
        src[SRC_LO]     = lo_q;
        src[SRC_ZHI]    = zhi_q;
        src[SRC_ZLO]    = zlo_q;
        src[SRC_PC]     = pc_q;
        src[SRC_MDR]    = mdr_q;
        src[SRC_INPORT] = inport_q;
        src[SRC_Y]      = y_q;
    end

    assign busMuxOut = src[encoderOut];

`ifdef DATAPATH_MUL_EN
    logic signed [2*WIDTH-1:0] mul_a, mul_b;
    assign mul_a = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    assign mul_b = {{WIDTH{busMuxOut[WIDTH-1]}}, busMuxOut};
`endif

    // ALU: A = Y, B = bus; IncPC uses B alone so PC+1 needs no Y load.
    always_comb begin
        alu_z = '0;
        if (IncPC) begin
            alu_z = {{WIDTH{1'b0}}, busMuxOut + WIDTH'(1)};
        end
`ifdef DATAPATH_MUL_EN
        else if (MUL) begin
            alu_z = (2*WIDTH)'(mul_a * mul_b);
        end
`endif
        else if (AND) begin
            alu_z = {{WIDTH{1'b0}}, y_q & busMuxOut};
        end else begin
            alu_z = {{WIDTH{1'b0}}, y_q - busMuxOut};
        end
    end

    assign BusMuxInR0  = r_q[0];  assign BusMuxInR1  = r_q[1];
    assign BusMuxInR2  = r_q[2];  assign BusMuxInR3  = r_q[3];
    assign BusMuxInR4  = r_q[4];  assign BusMuxInR5  = r_q[5];
    assign BusMuxInR6  = r_q[6];  assign BusMuxInR7  = r_q[7];
    assign BusMuxInR8  = r_q[8];  assign BusMuxInR9  = r_q[9];
    assign BusMuxInR10 = r_q[10]; assign BusMuxInR11 = r_q[11];
    assign BusMuxInR12 = r_q[12]; assign BusMuxInR13 = r_q[13];
    assign BusMuxInR14 = r_q[14]; assign BusMuxInR15 = r_q[15];
    assign BusMuxInHI     = hi_q;
    assign BusMuxInLO     = lo_q;
    assign BusMuxInZhi    = zhi_q;
    assign BusMuxInZlo    = zlo_q;
    assign BusMuxInPC     = pc_q;
    assign BusMuxInMDR    = mdr_q;
    assign BusMuxInInport = inport_q;
    assign BusMuxInY      = y_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized transfers
// checked against a register-array model indexed by bus-source code.
module tb_datapath;

    localparam int I_HI = 16, I_LO = 17, I_PC = 18, I_MDR = 19, I_INP = 20;
    localparam int I_Z = 21, I_Y = 22, I_MAR = 23, I_IR = 24;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [23:0] osel;      // bit = bus-source code
    logic        zout;
    logic [24:0] isel;      // 0..15 GPRs, then I_* indices
    logic        read, incpc, and_op, mul_op;
    logic [31:0] mdatain;
    logic [31:0] bus;
    logic [4:0]  enc;
    logic [31:0] obs [24];

    logic [31:0] mv [24];   // model value per bus-source code
    logic [31:0] mir, mmar;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 Clock = ~Clock;

    datapath dut (
        .Clock(Clock),
        .R0in(isel[0]),   .R1in(isel[1]),   .R2in(isel[2]),   .R3in(isel[3]),
        .R4in(isel[4]),   .R5in(isel[5]),   .R6in(isel[6]),   .R7in(isel[7]),
        .R8in(isel[8]),   .R9in(isel[9]),   .R10in(isel[10]), .R11in(isel[11]),
        .R12in(isel[12]), .R13in(isel[13]), .R14in(isel[14]), .R15in(isel[15]),
        .HIin(isel[I_HI]), .LOin(isel[I_LO]), .PCin(isel[I_PC]), .MDRin(isel[I_MDR]),
        .INPORTin(isel[I_INP]), .Zin(isel[I_Z]), .Yin(isel[I_Y]), .MARin(isel[I_MAR]),
        .IRin(isel[I_IR]), .AND(and_op),
        .R0out(osel[0]),   .R1out(osel[1]),   .R2out(osel[2]),   .R3out(osel[3]),
        .R4out(osel[4]),   .R5out(osel[5]),   .R6out(osel[6]),   .R7out(osel[7]),
        .R8out(osel[8]),   .R9out(osel[9]),   .R10out(osel[10]), .R11out(osel[11]),
        .R12out(osel[12]), .R13out(osel[13]), .R14out(osel[14]), .R15out(osel[15]),
        .HIout(osel[16]), .LOout(osel[17]), .ZHIout(osel[18]), .ZLOout(osel[19]),
        .PCout(osel[20]), .MDRout(osel[21]), .INPORTout(osel[22]), .Zout(zout),
        .Yout(osel[23]), .Read(read), .IncPC(incpc),
`ifdef DATAPATH_MUL_EN
        .MUL(mul_op),
`endif
        .Mdatain(mdatain), .busMuxOut(bus), .encoderOut(enc),
        .BusMuxInR0(obs[0]),   .BusMuxInR1(obs[1]),   .BusMuxInR2(obs[2]),   .BusMuxInR3(obs[3]),
        .BusMuxInR4(obs[4]),   .BusMuxInR5(obs[5]),   .BusMuxInR6(obs[6]),   .BusMuxInR7(obs[7]),
        .BusMuxInR8(obs[8]),   .BusMuxInR9(obs[9]),   .BusMuxInR10(obs[10]), .BusMuxInR11(obs[11]),
        .BusMuxInR12(obs[12]), .BusMuxInR13(obs[13]), .BusMuxInR14(obs[14]), .BusMuxInR15(obs[15]),
        .BusMuxInHI(obs[16]), .BusMuxInLO(obs[17]), .BusMuxInZhi(obs[18]), .BusMuxInZlo(obs[19]),
        .BusMuxInPC(obs[20]), .BusMuxInMDR(obs[21]), .BusMuxInInport(obs[22]), .BusMuxInY(obs[23]),
        .Resetn(Resetn)
    );

    function automatic logic [4:0] model_code();
        logic [23:0] s;
        logic [4:0]  c;
        s = osel;
        s[19] = s[19] | zout;
        c = 5'd31;
        for (int i = 23; i >= 0; i--) if (s[i]) c = 5'(i);
        return c;
    endfunction

    function automatic logic [31:0] model_bus();
        logic [4:0] c;
        c = model_code();
        return (c == 5'd31) ? 32'h0 : mv[c];
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] b);
        logic [31:0] a;
        a = mv[23];
        if (incpc) return {32'h0, b + 32'd1};
`ifdef DATAPATH_MUL_EN
        if (mul_op) return 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
        if (and_op) return {32'h0, a & b};
        return {32'h0, a - b};
    endfunction

    task automatic idle();
        osel = '0; zout = 0; isel = '0; read = 0; incpc = 0; and_op = 0; mul_op = 0;
        mdatain = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 24; i++) mv[i] = '0;
        mir = '0; mmar = '0;
    endtask

    // One clock: compute the transfer from the model, tick, then update the model.
    task automatic step();
        logic [31:0] b;
        logic [63:0] z;
        b = model_bus();
        z = model_alu(b);
        @(posedge Clock);
        for (int i = 0; i < 16; i++) if (isel[i]) mv[i] = b;
        if (isel[I_HI])  mv[16] = b;
        if (isel[I_LO])  mv[17] = b;
        if (isel[I_PC])  mv[20] = b;
        if (isel[I_MDR]) mv[21] = read ? mdatain : b;
        if (isel[I_INP]) mv[22] = b;
        if (isel[I_Z])   begin mv[18] = z[63:32]; mv[19] = z[31:0]; end
        if (isel[I_Y])   mv[23] = b;
        if (isel[I_MAR]) mmar = b;
        if (isel[I_IR])  mir = b;
        #1;
        idle();
    endtask

    // Load a GPR with a constant through Mdatain -> MDR -> bus.
    task automatic load_gpr(input int r, input logic [31:0] v);
        mdatain = v; read = 1; isel[I_MDR] = 1; step();
        osel[21] = 1; isel[r] = 1; step();
    endtask

    task automatic test_reset();
        idle(); model_clear();
        Resetn = 0;
        #3;
        for (int i = 0; i < 24; i++) begin
            n_cmp++;
            if (obs[i] !== 32'h0) begin n_err++; $display("FAIL reset_reg[%0d]: got %h expected 0", i, obs[i]); end
        end
        n_cmp++;
        if (enc !== 5'd31) begin n_err++; $display("FAIL reset_enc: got %0d expected 31", enc); end
        n_cmp++;
        if (bus !== 32'h0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", bus); end
        @(negedge Clock);
        Resetn = 1;
    endtask

    task automatic test_load_path();
        mdatain = 32'h12; read = 1; isel[I_MDR] = 1; step();
        n_cmp++;
        if (obs[21] !== 32'h12) begin n_err++; $display("FAIL load_mdr: got %h expected 12", obs[21]); end
        osel[21] = 1; isel[4] = 1; #1;
        n_cmp++;
        if (enc !== 5'd21) begin n_err++; $display("FAIL load_enc: got %0d expected 21", enc); end
        n_cmp++;
        if (bus !== 32'h12) begin n_err++; $display("FAIL load_bus: got %h expected 12", bus); end
        step();
        n_cmp++;
        if (obs[4] !== 32'h12) begin n_err++; $display("FAIL load_r4: got %h expected 12", obs[4]); end
    endtask

    task automatic test_fetch();
        n_cmp++;
        if (obs[20] !== 32'h0) begin n_err++; $display("FAIL fetch_pc0: got %h expected 0", obs[20]); end
        osel[20] = 1; isel[I_MAR] = 1; incpc = 1; isel[I_Z] = 1; step();
        n_cmp++;
        if (obs[19] !== 32'h1) begin n_err++; $display("FAIL fetch_zlo: got %h expected 1", obs[19]); end
        n_cmp++;
        if (obs[18] !== 32'h0) begin n_err++; $display("FAIL fetch_zhi: got %h expected 0", obs[18]); end
        osel[19] = 1; isel[I_PC] = 1; read = 1; isel[I_MDR] = 1; mdatain = 32'h20918000; step();
        n_cmp++;
        if (obs[20] !== 32'h1) begin n_err++; $display("FAIL fetch_pc: got %h expected 1", obs[20]); end
        n_cmp++;
        if (obs[21] !== 32'h20918000) begin n_err++; $display("FAIL fetch_mdr: got %h expected 20918000", obs[21]); end
        osel[21] = 1; isel[I_IR] = 1; step();
        n_cmp++;
        if (dut.ir_q !== 32'h20918000) begin n_err++; $display("FAIL fetch_ir: got %h expected 20918000", dut.ir_q); end
    endtask

    task automatic test_and();
        load_gpr(2, 32'h12);
        load_gpr(3, 32'h14);
        osel[2] = 1; isel[I_Y] = 1; step();
        osel[3] = 1; and_op = 1; isel[I_Z] = 1; step();
        n_cmp++;
        if (obs[19] !== 32'h10) begin n_err++; $display("FAIL and_zlo: got %h expected 10", obs[19]); end
        n_cmp++;
        if (obs[18] !== 32'h0) begin n_err++; $display("FAIL and_zhi: got %h expected 0", obs[18]); end
        osel[19] = 1; isel[0] = 1; step();
        n_cmp++;
        if (obs[0] !== 32'h10) begin n_err++; $display("FAIL and_r0: got %h expected 10", obs[0]); end
    endtask

    task automatic test_sub_wrap();
        load_gpr(6, 32'h18);
        osel[3] = 1; isel[I_Y] = 1; step();
        osel[6] = 1; isel[I_Z] = 1; step();
        n_cmp++;
        if (obs[19] !== 32'hFFFFFFFC) begin n_err++; $display("FAIL sub_zlo: got %h expected fffffffc", obs[19]); end
        n_cmp++;
        if (obs[18] !== 32'h0) begin n_err++; $display("FAIL sub_zhi: got %h expected 0", obs[18]); end
    endtask

    task automatic test_priority_idle();
        load_gpr(5, 32'hA5A5_0005);
        osel[5] = 1; osel[20] = 1; #1;
        n_cmp++;
        if (enc !== 5'd5) begin n_err++; $display("FAIL prio_enc: got %0d expected 5", enc); end
        n_cmp++;
        if (bus !== 32'hA5A5_0005) begin n_err++; $display("FAIL prio_bus: got %h expected a5a50005", bus); end
        idle(); zout = 1; #1;
        n_cmp++;
        if (enc !== 5'd19) begin n_err++; $display("FAIL zout_enc: got %0d expected 19", enc); end
        idle(); #1;
        n_cmp++;
        if (enc !== 5'd31) begin n_err++; $display("FAIL idle_enc: got %0d expected 31", enc); end
        n_cmp++;
        if (bus !== 32'h0) begin n_err++; $display("FAIL idle_bus: got %h expected 0", bus); end
    endtask

    task automatic test_same_edge();
        logic [31:0] old;
        old = mv[21];
        osel[21] = 1; isel[I_MDR] = 1; read = 1; mdatain = 32'hCAFE_F00D; #1;
        n_cmp++;
        if (bus !== old) begin n_err++; $display("FAIL same_edge_bus: got %h expected %h", bus, old); end
        step();
        n_cmp++;
        if (obs[21] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL same_edge_mdr: got %h expected cafef00d", obs[21]); end
    endtask

    task automatic test_random();
        logic [4:0]  ec;
        logic [31:0] eb;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: osel = '0;
                1, 2: osel = 24'(1) << $urandom_range(0, 23);
                default: osel = (24'(1) << $urandom_range(0, 23)) | (24'(1) << $urandom_range(0, 23));
            endcase
            zout    = ($urandom_range(0, 9) == 0);
            isel    = 25'($urandom & $urandom & $urandom);
            read    = 1'($urandom);
            incpc   = ($urandom_range(0, 3) == 0);
            and_op  = 1'($urandom);
            mul_op  = 1'($urandom);
            mdatain = $urandom;
            #1;
            ec = model_code();
            eb = model_bus();
            n_cmp++;
            if (enc !== ec) begin n_err++; $display("FAIL rand_enc[%0d]: got %0d expected %0d", n, enc, ec); end
            n_cmp++;
            if (bus !== eb) begin n_err++; $display("FAIL rand_bus[%0d]: got %h expected %h", n, bus, eb); end
            step();
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (obs[i] !== mv[i]) begin n_err++; $display("FAIL rand_reg[%0d][%0d]: got %h expected %h", n, i, obs[i], mv[i]); end
            end
            n_cmp++;
            if (dut.ir_q !== mir) begin n_err++; $display("FAIL rand_ir[%0d]: got %h expected %h", n, dut.ir_q, mir); end
        end
    endtask

    task automatic test_async_reset();
        load_gpr(9, 32'h1234_5678);
        osel[9] = 1; isel[4] = 1; isel[I_Y] = 1;
        @(posedge Clock);
        #2;
        Resetn = 0;
        #1;
        model_clear();
        for (int i = 0; i < 24; i++) begin
            n_cmp++;
            if (obs[i] !== 32'h0) begin n_err++; $display("FAIL async_reset_reg[%0d]: got %h expected 0", i, obs[i]); end
        end
        idle();
        @(negedge Clock);
        Resetn = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_path();
        test_fetch();
        test_and();
        test_sub_wrap();
        test_priority_idle();
        test_same_edge();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
